// File: rtl/alu_pkg.sv
// Shared constants, ALU opcode encodings and request/state types for the
// operand-issue stage wrapped around the 16-bit ALU.
package alu_pkg;

    localparam int DATA_W  = 16;
    localparam int SEL_W   = 4;
    localparam int REG_CNT = 8;
    localparam int ADDR_W  = 3;

    // ALU opcode encodings; unlisted codes produce zero
    localparam logic [SEL_W-1:0] OP_ADD   = 4'd1;
    localparam logic [SEL_W-1:0] OP_SUB   = 4'd3;
    localparam logic [SEL_W-1:0] OP_AND   = 4'd5;
    localparam logic [SEL_W-1:0] OP_OR    = 4'd7;
    localparam logic [SEL_W-1:0] OP_XOR   = 4'd9;
    localparam logic [SEL_W-1:0] OP_SHL   = 4'd10;
    localparam logic [SEL_W-1:0] OP_SHR   = 4'd11;
    localparam logic [SEL_W-1:0] OP_NOT   = 4'd13;
    localparam logic [SEL_W-1:0] OP_PASSB = 4'd15;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
    } alu_req_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } exec_state_t;

endpackage

// File: rtl/alu_regfile.sv
// 8 x 16-bit register file with two asynchronous read ports and two write
// ports (direct load and ALU write-back); write-back wins on an address clash.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] regs [REG_CNT];

    // The write-back assignment comes last so it overrides a same-address load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
            if (wb_en) begin
                regs[wb_addr] <= wb_data;
            end
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_operand_issue.sv
// Operand-issue and write-back stage: reads/forwards operands, registers them
// into the ALU, and writes the ALU result back one cycle later.
module alu_operand_issue
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_resault,
    output logic              busy,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    alu_req_t          req;
    exec_state_t       state_q;
    exec_state_t       state_d;
    logic              fire;
    logic              e_vld;
    logic [ADDR_W-1:0] e_rd;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    assign req      = '{sel: in_sel, rd: in_rd, rs1: in_rs1, rs2: in_rs2};
    assign in_ready = !ld_valid;
    assign fire     = in_valid && in_ready;
    assign e_vld    = (state_q == EXEC);
    assign busy     = e_vld;

    alu_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (req.rs1),
        .rd_data_a (rf_a),
        .rd_addr_b (req.rs2),
        .rd_data_b (rf_b),
        .ld_en     (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .wb_en     (e_vld),
        .wb_addr   (e_rd),
        .wb_data   (alu_resault)
    );

    // The result still in the ALU has not reached the register file yet
    assign opnd_a = (e_vld && (req.rs1 == e_rd)) ? alu_resault : rf_a;
    assign opnd_b = (e_vld && (req.rs2 == e_rd)) ? alu_resault : rf_b;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = fire ? EXEC : IDLE;
            EXEC:    state_d = fire ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alu_A   <= '0;
            alu_B   <= '0;
            alu_sel <= '0;
            e_rd    <= '0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                alu_A   <= opnd_a;
                alu_B   <= opnd_b;
                alu_sel <= req.sel;
                e_rd    <= req.rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= e_vld;
            if (e_vld) begin
                wb_rd   <= e_rd;
                wb_data <= alu_resault;
            end
        end
    end

endmodule
